pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Next-address controller for the 16-bit program counter register. Each cycle it computes the
//  value presented on the PC register's data input (E), from the registered PC output (Saida).
//  It runs a fetch handshake with instruction memory and holds the PC during fetch/execute waits.
//  It applies redirects (jump, taken branch, call, return) through an internal return-address stack.
// PARAMETERS
//  AW         16       address width; must match the PC register width
//  RS_DEPTH   4        return-stack entries (power of 2, >=2)
//  RESET_VEC  16'h0000 address of the first fetch after reset
// PORTS
//  clk        in   1   rising-edge clock
//  Reset      in   1   asynchronous, active-low reset (0 = reset)
//  start      in   1   1-cycle pulse: leave IDLE, begin fetching at RESET_VEC
//  pc_cur     in   AW  current PC (PC register output)
//  pc_next    out  AW  value to drive on PC register input; PC loads it every clk
//  imem_req   out  1   instruction fetch request, address = pc_cur
//  imem_ack   in   1   fetch data valid this cycle
//  ir_valid   out  1   1-cycle pulse: instruction word captured, decoder may act
//  exec_done  in   1   execute stage finished; redirect inputs are sampled with it
//  br_taken   in   1   conditional branch taken (target = br_target)
//  br_target  in   AW  branch target
//  jmp        in   1   unconditional jump to br_target
//  call       in   1   push pc_cur+1, go to br_target
//  ret        in   1   pop return stack, go to popped address
//  halt       in   1   enter HALT after this instruction
//  busy       out  1   1 in FETCH or EXEC
//  rs_err     out  1   sticky: push on full or pop on empty
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE, pc_next=RESET_VEC, imem_req=0, ir_valid=0, busy=0,
//  rs_err=0, stack pointer=0. All outputs take these values immediately and hold them
//  while Reset=0.
//  States: IDLE, FETCH, EXEC, HALT (shared enum).
//   IDLE : pc_next=RESET_VEC; start=1 -> FETCH.
//   FETCH: imem_req=1, pc_next=pc_cur (hold).
//          imem_ack=1 -> ir_valid=1 for one cycle, go to EXEC.
//          imem_req stays 1 until ack; no timeout.
//   EXEC : pc_next=pc_cur until exec_done=1. On exec_done=1, the redirect is computed
//          combinationally this same cycle, so the PC updates on the next edge.
//          After exec_done, go to FETCH, or to HALT if halt=1.
//   HALT : pc_next=pc_cur forever. Exit only via reset; start is ignored.
//  Redirect priority on exec_done, highest first:
//   jmp -> br_target
//   call -> br_target, push pc_cur+1
//   ret -> stack top, pop
//   br_taken -> br_target
//   none -> pc_cur+1
//  Lower-priority redirect inputs asserted in the same cycle are ignored.
//  Arithmetic: pc_cur+1 is modulo 2^AW (16'hFFFF+1 = 16'h0000); no flag is raised.
//  Return stack:
//   - Push when full: oldest entry is overwritten (circular), rs_err set.
//   - Pop when empty: target = pc_cur+1, pointer unchanged, rs_err set.
//   - rs_err is cleared only by reset.
//  Redirect inputs are ignored outside EXEC. exec_done in FETCH/IDLE is ignored.
//  Reset mid-fetch drops imem_req in the same cycle; the pending ack is ignored after reset.
//  Latency: 1 cycle minimum from imem_ack to ir_valid (ack registered).
//   Minimum instruction period: FETCH(1, ack at once) + EXEC(1, exec_done at once) = 2 cycles.
// STRUCTURE
//  Package pc_seq_pkg: state enum (IDLE/FETCH/EXEC/HALT), AW, RESET_VEC default.
//  Sub-module pc_ret_stack: RS_DEPTH x AW register file, push/pop/full/empty, circular
//  overwrite. FSM and next-PC mux stay in pc_sequencer; 150-250 lines total.
// TESTING
//  1 Reset=0 mid-FETCH -> imem_req=0 and pc_next=16'h0000 same cycle; after release + start,
//    first fetch address = 16'h0000.
//  2 Sequential run: ack and exec_done each after 1 cycle, no redirects -> PC 0,1,2,3;
//    ir_valid pulses once per instruction.
//  3 At PC 16'h0010: call(target 16'h0100), then ret at 16'h0100 -> PC 16'h0100, then 16'h0011.
//  4 jmp+br_taken+ret together, br_target=16'h0040 -> PC=16'h0040; stack unchanged.
//  5 Five nested calls (RS_DEPTH=4) -> rs_err=1; then 4 rets return to call sites 5,4,3,2.
//    Fifth ret: pop on empty, PC = pc_cur+1.
//  6 PC=16'hFFFF, no redirect -> PC 16'h0000.
//    halt with exec_done -> HALT; PC frozen 20 cycles; start ignored.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   PC_AW        : default address width (matches the PC register)
//   PC_RESET_VEC : default address of the first fetch after reset
//   pc_state_e   : sequencer states (idle, fetch, execute, halted)
package pc_seq_pkg;

  localparam int unsigned      PC_AW        = 16;
  localparam logic [PC_AW-1:0] PC_RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } pc_state_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data on top (overwrites the oldest entry when full)
//   pop        : drop the top entry (no effect on the pointer when empty)
//   push_data  : return address to store
//   top_data   : current top entry (valid when !empty)
//   empty      : no entries held
//   err        : sticky, set by a push when full or a pop when empty
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW    = PC_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          empty,
  output logic          err
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, top_idx;
  logic [PW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          full;

  // wp points at the next free slot; when full it points at the oldest
  // entry, so a push there naturally overwrites it.
  assign top_idx  = wp_q - 1'b1;
  assign top_data = mem_q[top_idx];
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign err      = err_q;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + 1'b1;
      if (full) err_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        wp_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter register.
//   clk, Reset          : clock, asynchronous active-low reset
//   start               : leave IDLE and begin fetching at RESET_VEC
//   pc_cur / pc_next    : PC register output / value the PC loads every clock
//   imem_req / imem_ack : instruction fetch handshake (address = pc_cur)
//   ir_valid            : one-cycle pulse, instruction word captured
//   exec_done           : execute finished; redirect inputs sampled with it
//   br_taken, jmp, call, ret, br_target : redirect controls and target
//   halt                : stop after the current instruction (reset to leave)
//   busy                : high in FETCH or EXEC
//   rs_err              : sticky return-stack overflow/underflow
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned   AW        = PC_AW,
  parameter int unsigned   RS_DEPTH  = 4,
  parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [AW-1:0] pc_cur,
  output logic [AW-1:0] pc_next,
  output logic          imem_req,
  input  logic          imem_ack,
  output logic          ir_valid,
  input  logic          exec_done,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          jmp,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  output logic          busy,
  output logic          rs_err
);

  pc_state_e     state_q, state_d;
  logic          ir_valid_q, ir_valid_d;
  logic          rs_push, rs_pop, rs_empty;
  logic [AW-1:0] rs_top, pc_inc;

  assign pc_inc   = pc_cur + AW'(1);
  assign ir_valid = ir_valid_q;

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (RS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (Reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (pc_inc),
    .top_data  (rs_top),
    .empty     (rs_empty),
    .err       (rs_err)
  );

  always_comb begin
    state_d    = state_q;
    ir_valid_d = 1'b0;
    pc_next    = pc_cur;
    imem_req   = 1'b0;
    busy       = 1'b0;
    rs_push    = 1'b0;
    rs_pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pc_next = RESET_VEC;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ack) begin
          ir_valid_d = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (exec_done) begin
          // Priority chain: the first asserted redirect wins, the rest are dropped.
          if (jmp) begin
            pc_next = br_target;
          end else if (call) begin
            rs_push = 1'b1;
            pc_next = br_target;
          end else if (ret) begin
            rs_pop  = 1'b1;
            pc_next = rs_empty ? pc_inc : rs_top;
          end else if (br_taken) begin
            pc_next = br_target;
          end else begin
            pc_next = pc_inc;
          end
          state_d = halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule
